scalar_alu_arbiter: RTL and testbench

- Shares the single scalar ALU between two requesters. Port 0 is the scalar issue stage. Port 1 is the auxiliary requester (loop/elevator bookkeeping, address updates).
- Fixed priority to port 0, with a starvation guard that forces a port-1 grant.
- Drives the combinational ALU from the granted request and captures the result in a one-entry registered response stage (valid/ready).
- Holds the architectural scalar flag register (Z/C/V), which only port-0 flag-setting ops update.

---
 rtl/scalar_alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_scalar_alu_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_alu_arbiter.sv
// Arbitrates the shared scalar ALU between the issue stage (port 0) and the auxiliary requester (port 1).
// Registers one response entry and the architectural {Z,C,V} flags.
package qtpa_pkg;
    typedef enum logic [4:0] {
        OP_NOP       = 5'd0,
        OP_ADD_IMM   = 5'd1,
        OP_ADD_REG   = 5'd2,
        OP_SUB_IMM   = 5'd3,
        OP_SUB_REG   = 5'd4,
        OP_AND_IMM   = 5'd5,
        OP_AND_REG   = 5'd6,
        OP_OR_IMM    = 5'd7,
        OP_OR_REG    = 5'd8,
        OP_CMP_IMM   = 5'd9,
        OP_CMP_REG   = 5'd10,
        OP_MOV_IMM   = 5'd11,
        OP_MOV_REG   = 5'd12,
        OP_SHL_IMM   = 5'd13,
        OP_SHL_REG   = 5'd14,
        OP_SHR_IMM   = 5'd15,
        OP_SHR_REG   = 5'd16,
        OP_LCSET_IMM = 5'd17,
        OP_LCSET_REG = 5'd18
    } op_t;
endpackage

module scalar_alu_arbiter
    import qtpa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH    = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [1:0]                          req_valid,
    output logic [1:0]                          req_ready,
    input  op_t                                 req_op [2],
    input  logic [1:0][DATA_WIDTH-1:0]          req_op1,
    input  logic [1:0][DATA_WIDTH-1:0]          req_op2,
    input  logic [1:0][TAG_WIDTH-1:0]           req_tag,
    output op_t                                 alu_op,
    output logic [DATA_WIDTH-1:0]               alu_op1,
    output logic [DATA_WIDTH-1:0]               alu_op2,
    input  logic [DATA_WIDTH-1:0]               alu_result,
    input  logic                                alu_flag_zero,
    input  logic                                alu_flag_carry,
    input  logic                                alu_flag_ovf,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic                                rsp_src,
    output logic [TAG_WIDTH-1:0]                rsp_tag,
    output logic [DATA_WIDTH-1:0]               rsp_result,
    output logic [2:0]                          flags_q
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic                  r_rsp_valid;
    logic                  r_rsp_src;
    logic [TAG_WIDTH-1:0]  r_rsp_tag;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic [2:0]            r_flags;
    logic [CNT_W-1:0]      r_starve_cnt;

    logic w_can_load;
    logic w_grant_vld;
    logic w_grant_port;
    logic w_accept;
    logic w_starved;
    op_t  w_op;

    function automatic logic sets_flags(input op_t op);
        case (op)
            OP_ADD_IMM, OP_ADD_REG, OP_SUB_IMM, OP_SUB_REG,
            OP_AND_IMM, OP_AND_REG, OP_OR_IMM,  OP_OR_REG,
            OP_CMP_IMM, OP_CMP_REG, OP_MOV_IMM, OP_MOV_REG,
            OP_SHL_IMM, OP_SHL_REG, OP_SHR_IMM, OP_SHR_REG: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    assign w_can_load = !r_rsp_valid || rsp_ready;
    assign w_starved  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant_port = 1'b0;
        if (w_starved && req_valid[1]) begin
            w_grant_vld  = 1'b1;
            w_grant_port = 1'b1;
        end else if (req_valid[0]) begin
            w_grant_vld  = 1'b1;
            w_grant_port = 1'b0;
        end else if (req_valid[1]) begin
            w_grant_vld  = 1'b1;
            w_grant_port = 1'b1;
        end
    end

    // Nothing is accepted while reset is held, so no requester loses a request to reset.
    assign w_accept = w_grant_vld && w_can_load && !rst;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant_port] = 1'b1;
        end
    end

    // With no grant the select defaults to port 0, keeping the ALU inputs defined.
    assign w_op    = req_op[w_grant_port];
    assign alu_op  = w_op;
    assign alu_op1 = req_op1[w_grant_port];
    assign alu_op2 = req_op2[w_grant_port];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_src    <= 1'b0;
            r_rsp_tag    <= '0;
            r_rsp_result <= '0;
            r_flags      <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_src    <= w_grant_port;
                r_rsp_tag    <= req_tag[w_grant_port];
                r_rsp_result <= (w_op == OP_CMP_IMM || w_op == OP_CMP_REG) ? '0 : alu_result;
                if (!w_grant_port && sets_flags(w_op)) begin
                    r_flags <= {alu_flag_zero, alu_flag_carry, alu_flag_ovf};
                end
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end

            if (!req_valid[1]) begin
                r_starve_cnt <= '0;
            end else if (w_accept && w_grant_port) begin
                r_starve_cnt <= '0;
            end else if (w_accept && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_src    = r_rsp_src;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_result = r_rsp_result;
    assign flags_q    = r_flags;

endmodule

// File: tb/tb_scalar_alu_arbiter.sv
// Bench for scalar_alu_arbiter: behavioural ALU, response scoreboard, flag model, per-scenario tasks.
module tb_scalar_alu_arbiter;
    import qtpa_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    op_t               req_op [2];
    logic [1:0][31:0]  req_op1;
    logic [1:0][31:0]  req_op2;
    logic [1:0][3:0]   req_tag;
    op_t               alu_op;
    logic [31:0]       alu_op1;
    logic [31:0]       alu_op2;
    logic [31:0]       alu_result;
    logic              alu_flag_zero;
    logic              alu_flag_carry;
    logic              alu_flag_ovf;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_src;
    logic [3:0]        rsp_tag;
    logic [31:0]       rsp_result;
    logic [2:0]        flags_q;

    typedef struct {
        logic        src;
        logic [3:0]  tag;
        logic [31:0] result;
    } rsp_t;

    rsp_t       sb [$];
    logic [2:0] exp_flags;
    int         n_cmp;
    int         n_err;

    scalar_alu_arbiter #(
        .DATA_WIDTH  (32),
        .TAG_WIDTH   (4),
        .STARVE_LIMIT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .req_tag       (req_tag),
        .alu_op        (alu_op),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_result    (alu_result),
        .alu_flag_zero (alu_flag_zero),
        .alu_flag_carry(alu_flag_carry),
        .alu_flag_ovf  (alu_flag_ovf),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_src       (rsp_src),
        .rsp_tag       (rsp_tag),
        .rsp_result    (rsp_result),
        .flags_q       (flags_q)
    );

    always #5 clk = ~clk;

    // Returns {result, Z, C, V}; carry on subtract means "no borrow".
    function automatic logic [34:0] ref_alu(input op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD_IMM, OP_ADD_REG: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0]; c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OP_SUB_IMM, OP_SUB_REG, OP_CMP_IMM, OP_CMP_REG: begin
                w = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = w[31:0]; c = w[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            OP_AND_IMM, OP_AND_REG:     r = a & b;
            OP_OR_IMM, OP_OR_REG:       r = a | b;
            OP_MOV_IMM, OP_MOV_REG,
            OP_LCSET_IMM, OP_LCSET_REG: r = b;
            OP_SHL_IMM, OP_SHL_REG:     r = a << b[4:0];
            OP_SHR_IMM, OP_SHR_REG:     r = a >> b[4:0];
            default:                    r = '0;
        endcase
        return {r, (r == 32'd0), c, v};
    endfunction

    function automatic logic is_flag_op(input op_t op);
        return (op inside {OP_ADD_IMM, OP_ADD_REG, OP_SUB_IMM, OP_SUB_REG, OP_AND_IMM, OP_AND_REG,
                           OP_OR_IMM, OP_OR_REG, OP_CMP_IMM, OP_CMP_REG, OP_MOV_IMM, OP_MOV_REG,
                           OP_SHL_IMM, OP_SHL_REG, OP_SHR_IMM, OP_SHR_REG});
    endfunction

    assign {alu_result, alu_flag_zero, alu_flag_carry, alu_flag_ovf} = ref_alu(alu_op, alu_op1, alu_op2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input op_t op, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] tag);
        req_valid[p] = v;
        req_op[p]    = op;
        req_op1[p]   = a;
        req_op2[p]   = b;
        req_tag[p]   = tag;
    endtask

    // Presents one request and returns just after the edge that accepted it.
    task automatic send(input int p, input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        logic acc;
        acc = 1'b0;
        set_port(p, 1'b1, op, a, b, tag);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (req_ready[p] === 1'b1) acc = 1'b1;
        end
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL send_timeout: port %0d got no ready within 20 cycles, required ready=1", p);
        end
        tick();
        req_valid[p] = 1'b0;
    endtask

    // Scoreboard: responses checked against pushed expectations, flags against the model.
    task automatic monitor();
        logic [34:0] res;
        forever begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== (sb.size() != 0)) begin
                n_err++;
                $display("FAIL sb_valid: rsp_valid=%b required %b", rsp_valid, (sb.size() != 0));
            end
            if (rsp_valid === 1'b1 && sb.size() != 0) begin
                n_cmp++;
                if ({rsp_src, rsp_tag, rsp_result} !== {sb[0].src, sb[0].tag, sb[0].result}) begin
                    n_err++;
                    $display("FAIL sb_rsp: src=%b tag=%h result=%h required src=%b tag=%h result=%h",
                             rsp_src, rsp_tag, rsp_result, sb[0].src, sb[0].tag, sb[0].result);
                end
                if (rsp_ready && !rst) void'(sb.pop_front());
            end
            n_cmp++;
            if (flags_q !== exp_flags) begin
                n_err++;
                $display("FAIL sb_flags: flags_q=%b required %b", flags_q, exp_flags);
            end
            if (rst) begin
                sb.delete();
                exp_flags = '0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (req_valid[p] && req_ready[p]) begin
                        res = ref_alu(req_op[p], req_op1[p], req_op2[p]);
                        sb.push_back('{src: (p == 1), tag: req_tag[p],
                                       result: (req_op[p] inside {OP_CMP_IMM, OP_CMP_REG}) ? 32'd0 : res[34:3]});
                        if (p == 0 && is_flag_op(req_op[0])) exp_flags = res[2:0];
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_result, flags_q, req_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b src=%b tag=%h result=%h flags=%b ready=%b required all 0",
                     rsp_valid, rsp_src, rsp_tag, rsp_result, flags_q, req_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_add_flags();
        send(0, OP_ADD_REG, 32'h7FFF_FFFF, 32'h1, 4'd3);
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_result, flags_q} !== {1'b1, 1'b0, 4'd3, 32'h8000_0000, 3'b001}) begin
            n_err++;
            $display("FAIL add_ovf: valid=%b src=%b tag=%h result=%h flags=%b required 1 0 3 80000000 001",
                     rsp_valid, rsp_src, rsp_tag, rsp_result, flags_q);
        end
        tick();
    endtask

    task automatic test_port1_and_cmp();
        send(1, OP_SUB_IMM, 32'd5, 32'd5, 4'd7);
        @(negedge clk);
        n_cmp++;
        if ({rsp_src, rsp_tag, rsp_result, flags_q} !== {1'b1, 4'd7, 32'd0, 3'b001}) begin
            n_err++;
            $display("FAIL port1_noflag: src=%b tag=%h result=%h flags=%b required 1 7 0 001",
                     rsp_src, rsp_tag, rsp_result, flags_q);
        end
        tick();
        send(0, OP_CMP_REG, 32'd5, 32'd5, 4'd2);
        @(negedge clk);
        n_cmp++;
        if ({rsp_result, flags_q[2]} !== {32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL cmp_eq: result=%h Z=%b required 0 1", rsp_result, flags_q[2]);
        end
        tick();
        send(0, OP_CMP_IMM, 32'd9, 32'd3, 4'd1);
        @(negedge clk);
        n_cmp++;
        if ({rsp_result, flags_q[2]} !== {32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL cmp_ne: result=%h Z=%b required 0 0", rsp_result, flags_q[2]);
        end
        tick();
    endtask

    task automatic test_lcset();
        send(0, OP_MOV_IMM, 32'd0, 32'd0, 4'd1);
        @(negedge clk);
        n_cmp++;
        if (flags_q !== 3'b100) begin
            n_err++;
            $display("FAIL mov_flags: flags=%b required 100", flags_q);
        end
        tick();
        send(0, OP_LCSET_IMM, 32'd0, 32'h10, 4'd4);
        @(negedge clk);
        n_cmp++;
        if ({rsp_result, flags_q} !== {32'h10, 3'b100}) begin
            n_err++;
            $display("FAIL lcset: result=%h flags=%b required 00000010 100", rsp_result, flags_q);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic [1:0] exp_g;
        set_port(0, 1'b1, OP_ADD_IMM, 32'd1, 32'd2, 4'd5);
        set_port(1, 1'b1, OP_ADD_IMM, 32'hFFFF_FFFF, 32'd1, 4'd9);
        for (int i = 0; i < 10; i++) begin
            exp_g = (i == 4 || i == 9) ? 2'b10 : 2'b01;
            @(negedge clk);
            n_cmp++;
            if (req_ready !== exp_g) begin
                n_err++;
                $display("FAIL starve_grant[%0d]: req_ready=%b required %b", i, req_ready, exp_g);
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_stall();
        send(0, OP_OR_IMM, 32'hF0, 32'h0F, 4'd6);
        rsp_ready = 1'b0;
        set_port(0, 1'b1, OP_AND_REG, 32'hFF, 32'h3C, 4'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({req_ready, rsp_valid, rsp_tag, rsp_result} !== {2'b00, 1'b1, 4'd6, 32'hFF}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: ready=%b valid=%b tag=%h result=%h required 00 1 6 000000ff",
                         i, req_ready, rsp_valid, rsp_tag, rsp_result);
            end
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL stall_reload: req_ready=%b required 01", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_tag, rsp_result} !== {1'b1, 4'd8, 32'h3C}) begin
            n_err++;
            $display("FAIL stall_nobubble: valid=%b tag=%h result=%h required 1 8 0000003c",
                     rsp_valid, rsp_tag, rsp_result);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            set_port(0, 1'b1, (i % 2 == 0) ? OP_SHL_REG : OP_SUB_REG, 32'(i * 3 + 1), 32'(i), 4'(i));
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 2'b01 || (i > 0 && rsp_valid !== 1'b1)) begin
                n_err++;
                $display("FAIL b2b[%0d]: req_ready=%b rsp_valid=%b required 01 1", i, req_ready, rsp_valid);
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_g;
        set_port(0, 1'b1, OP_MOV_IMM, 32'd0, 32'd0, 4'hA);
        set_port(1, 1'b1, OP_ADD_IMM, 32'd4, 32'd4, 4'hB);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 2'b01) begin
                n_err++;
                $display("FAIL pre_reset_grant[%0d]: req_ready=%b required 01", i, req_ready);
            end
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ready: req_ready=%b required 00", req_ready);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, flags_q} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid: rsp_valid=%b flags=%b required 0 000", rsp_valid, flags_q);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            exp_g = (i == 4) ? 2'b10 : 2'b01;
            n_cmp++;
            if (req_ready !== exp_g) begin
                n_err++;
                $display("FAIL post_reset_grant[%0d]: req_ready=%b required %b", i, req_ready, exp_g);
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_flags = '0;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_op1   = '0;
        req_op2   = '0;
        req_tag   = '0;
        req_op[0] = OP_NOP;
        req_op[1] = OP_NOP;
        fork
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish within time bound");
                $fatal(1, "watchdog expired");
            end
        join_none
        test_reset();
        fork
            monitor();
        join_none
        test_add_flags();
        test_port1_and_cmp();
        test_lcset();
        test_starvation();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
